// File: rtl/audio_flash_pkg.sv
// Shared constants for the flash audio playback path: sequencer state codes,
// sample width and the full-word byte enable.
package audio_flash_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [3:0] FLASH_BE_ALL = 4'hF;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ       = 3'd1;
    localparam logic [2:0] WAIT_DATA = 3'd2;
    localparam logic [2:0] FIRST     = 3'd3;
    localparam logic [2:0] SECOND    = 3'd4;

endpackage

// File: rtl/flash_sample_sequencer.sv
// Fetches one 32-bit flash word per sample pair over an Avalon-MM read master
// and plays its two halves out on consecutive sample ticks.
module flash_sample_sequencer
    import audio_flash_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int SAMPLE_W = audio_flash_pkg::SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  pause,
    input  logic                  increment,
    input  logic [ADDR_W-1:0]     word_addr,
    output logic                  addr_advance,
    output logic                  flash_read,
    output logic [ADDR_W-1:0]     flash_address,
    output logic [3:0]            flash_byteenable,
    input  logic                  flash_waitrequest,
    input  logic [2*SAMPLE_W-1:0] flash_readdata,
    input  logic                  flash_readdatavalid,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  late
);

    logic [2:0]            state;
    logic [2*SAMPLE_W-1:0] word_buf;
    logic                  forward;
    logic                  tick_ok;
    logic                  accept;
    logic                  data_pending;
    logic [SAMPLE_W-1:0]   first_half;
    logic [SAMPLE_W-1:0]   second_half;

    assign flash_read       = (state == REQ);
    assign flash_byteenable = FLASH_BE_ALL;
    assign tick_ok          = sample_tick && !pause;
    assign accept           = flash_read && !flash_waitrequest;
    assign data_pending     = (state == IDLE) || (state == REQ) || (state == WAIT_DATA);

    // Half order is taken from the order latched with the word, not the live input.
    assign first_half  = forward ? word_buf[SAMPLE_W-1:0] : word_buf[2*SAMPLE_W-1:SAMPLE_W];
    assign second_half = forward ? word_buf[2*SAMPLE_W-1:SAMPLE_W] : word_buf[SAMPLE_W-1:0];

    // NOTE: all state here uses non-blocking assignments so every branch sees
    // pre-edge values; blocking ones would let the late-tick logic see the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            flash_address <= '0;
            word_buf      <= '0;
            forward       <= 1'b1;
            addr_advance  <= 1'b0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            late          <= 1'b0;
        end else begin
            addr_advance <= 1'b0;
            sample_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!pause) begin
                        flash_address <= word_addr;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (accept) begin
                        addr_advance <= 1'b1;
                        state        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_readdatavalid) begin
                        word_buf <= flash_readdata;
                        forward  <= increment;
                        state    <= FIRST;
                    end
                end
                FIRST: begin
                    if (tick_ok) begin
                        sample_out   <= first_half;
                        sample_valid <= 1'b1;
                        state        <= SECOND;
                    end
                end
                SECOND: begin
                    if (tick_ok) begin
                        sample_out    <= second_half;
                        sample_valid  <= 1'b1;
                        flash_address <= word_addr;
                        state         <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            // A tick with no word ready repeats the old sample and flags the underrun.
            if (tick_ok && data_pending) begin
                sample_valid <= 1'b1;
                late         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed plus randomized bench for flash_sample_sequencer with a queue-based
// model of the samples the sequencer owes the audio path.
module tb_flash_sample_sequencer;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  sample_tick = 1'b0;
    logic                  pause = 1'b1;
    logic                  increment = 1'b1;
    logic [ADDR_W-1:0]     word_addr;
    logic                  addr_advance;
    logic                  flash_read;
    logic [ADDR_W-1:0]     flash_address;
    logic [3:0]            flash_byteenable;
    logic                  flash_waitrequest = 1'b1;
    logic [2*SAMPLE_W-1:0] flash_readdata = '0;
    logic                  flash_readdatavalid = 1'b0;
    logic [SAMPLE_W-1:0]   sample_out;
    logic                  sample_valid;
    logic                  late;

    int checks = 0;
    int errors = 0;

    // Address generator: base plus one step per advance pulse.
    logic [ADDR_W-1:0] addr_base = '0;
    logic [ADDR_W-1:0] adv_count = '0;
    assign word_addr = addr_base + adv_count;

    always @(posedge clk) if (addr_advance === 1'b1) adv_count <= adv_count + 1'b1;

    // Reference model: samples owed in playback order, last sample heard, sticky late.
    logic [SAMPLE_W-1:0] owed[$];
    logic [SAMPLE_W-1:0] last_out = '0;
    logic                late_exp = 1'b0;
    logic [ADDR_W-1:0]   model_addr = '0;

    flash_sample_sequencer #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .sample_tick         (sample_tick),
        .pause               (pause),
        .increment           (increment),
        .word_addr           (word_addr),
        .addr_advance        (addr_advance),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .late                (late)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a read request, stall it, accept it and confirm exactly one advance.
    task automatic accept_read(input string tag, input int stall);
        int                waited;
        logic [ADDR_W-1:0] adv_before;
        waited = 0;
        while (flash_read !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_req"}, flash_read, 1'b1);
        check({tag, "_addr"}, flash_address, model_addr);
        adv_before = adv_count;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_rd"}, flash_read, 1'b1);
            check({tag, "_stall_addr"}, flash_address, model_addr);
            check({tag, "_stall_adv"}, addr_advance, 1'b0);
        end
        flash_waitrequest = 1'b0;
        @(negedge clk);
        flash_waitrequest = 1'b1;
        check({tag, "_adv"}, addr_advance, 1'b1);
        check({tag, "_rd_drop"}, flash_read, 1'b0);
        @(negedge clk);
        check({tag, "_adv_once"}, addr_advance, 1'b0);
        check({tag, "_adv_count"}, adv_count, adv_before + 1'b1);
        model_addr = model_addr + 1'b1;
    endtask

    // Return a word after some latency; the model queues its halves in playback order.
    task automatic return_data(input int lat, input logic [2*SAMPLE_W-1:0] data);
        logic fwd;
        repeat (lat - 1) @(negedge clk);
        flash_readdatavalid = 1'b1;
        flash_readdata      = data;
        fwd                 = increment;
        @(negedge clk);
        flash_readdatavalid = 1'b0;
        flash_readdata      = $urandom;
        if (fwd) begin
            owed.push_back(data[15:0]);
            owed.push_back(data[31:16]);
        end else begin
            owed.push_back(data[31:16]);
            owed.push_back(data[15:0]);
        end
    endtask

    task automatic do_tick(input string tag);
        logic exp_valid;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        if (pause) begin
            exp_valid = 1'b0;
        end else if (owed.size() > 0) begin
            exp_valid = 1'b1;
            last_out  = owed.pop_front();
        end else begin
            exp_valid = 1'b1;
            late_exp  = 1'b1;
        end
        check({tag, "_valid"}, sample_valid, exp_valid);
        check({tag, "_out"}, sample_out, last_out);
        check({tag, "_late"}, late, late_exp);
        @(negedge clk);
        check({tag, "_valid_pulse"}, sample_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_read", flash_read, 1'b0);
        check("rst_adv", addr_advance, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_late", late, 1'b0);
        check("rst_addr", flash_address, '0);
        check("rst_out", sample_out, '0);
        check("rst_be", flash_byteenable, 4'hF);

        // Basic forward fetch with a 2-cycle stall
        increment = 1'b1;
        pause     = 1'b0;
        reset     = 1'b0;
        accept_read("fwd", 2);
        return_data(4, 32'hBBBB_AAAA);
        do_tick("fwd_t1");
        check("fwd_first", last_out, 16'hAAAA);
        do_tick("fwd_t2");
        check("fwd_refetch", flash_read, 1'b1);

        // Reverse order; a direction change mid-word does not affect it
        increment = 1'b0;
        accept_read("rev", 0);
        return_data(1, 32'h1234_5678);
        do_tick("rev_t1");
        increment = 1'b1;
        do_tick("rev_t2");
        check("rev_refetch", flash_read, 1'b1);

        // Pause in FIRST drops ticks silently
        increment = 1'($urandom_range(0, 1));
        accept_read("pz", 1);
        return_data(2, $urandom);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) do_tick("pz_drop");
        pause = 1'b0;
        do_tick("pz_t1");
        do_tick("pz_t2");

        // Late tick while waiting for data; late stays set afterwards
        accept_read("late", 0);
        do_tick("late_tick");
        return_data(1, $urandom);
        do_tick("late_t1");
        do_tick("late_t2");
        check("late_sticky", late, 1'b1);

        // Long stall
        accept_read("stall", 10);
        return_data(3, $urandom);
        do_tick("stall_t1");
        do_tick("stall_t2");

        // Randomized words, stalls, latencies, directions and pauses
        for (int k = 0; k < 6; k++) begin
            increment = 1'($urandom_range(0, 1));
            accept_read("rnd", $urandom_range(0, 4));
            return_data($urandom_range(1, 5), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                pause = 1'b1;
                do_tick("rnd_pz");
                pause = 1'b0;
            end
            do_tick("rnd_t1");
            increment = 1'($urandom_range(0, 1));
            do_tick("rnd_t2");
            check("rnd_refetch", flash_read, 1'b1);
        end

        // Reset in WAIT_DATA aborts the transaction
        accept_read("mid", 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_read", flash_read, 1'b0);
        check("mid_adv", addr_advance, 1'b0);
        check("mid_valid", sample_valid, 1'b0);
        check("mid_late", late, 1'b0);
        check("mid_addr", flash_address, '0);
        check("mid_out", sample_out, '0);
        owed.delete();
        last_out   = '0;
        late_exp   = 1'b0;
        addr_base  = 23'h1234;
        @(negedge clk);
        model_addr = word_addr;
        increment  = 1'b1;
        reset      = 1'b0;
        accept_read("post", 1);
        return_data(2, 32'hCAFE_F00D);
        do_tick("post_t1");
        check("post_first", last_out, 16'hF00D);
        do_tick("post_t2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
